// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - FSM states, divider profile ROM and defaults shared by the rPLL reconfiguration controller
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } pll_profile_t;

  localparam int MAX_PROFILES    = 16;
  localparam int DEFAULT_PROFILE = 0;

  // Codes are stored pre-inverted for dynamic selection: sel = 64 - divider, odsel = 64 - ODIV/2.
  localparam pll_profile_t PROF_IDIV2_FB19_OD4  = '{idsel: 6'd62, fbdsel: 6'd45, odsel: 6'd62};
  localparam pll_profile_t PROF_IDIV2_FB9_OD8   = '{idsel: 6'd62, fbdsel: 6'd55, odsel: 6'd60};
  localparam pll_profile_t PROF_IDIV3_FB20_OD8  = '{idsel: 6'd61, fbdsel: 6'd44, odsel: 6'd60};
  localparam pll_profile_t PROF_IDIV1_FB10_OD16 = '{idsel: 6'd63, fbdsel: 6'd54, odsel: 6'd56};

  localparam pll_profile_t PROFILE_ROM [MAX_PROFILES] = '{
    0:       PROF_IDIV2_FB19_OD4,
    1:       PROF_IDIV2_FB9_OD8,
    2:       PROF_IDIV3_FB20_OD8,
    3:       PROF_IDIV1_FB10_OD16,
    default: PROF_IDIV2_FB19_OD4
  };

  function automatic pll_profile_t profile_codes(input logic [3:0] idx);
    return PROFILE_ROM[idx];
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer bringing the rPLL LOCK into the clkin domain
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - rPLL dynamic-divider sequencer: reset, lock, settle, retry and profile requests
// Optional macro PLL_LOCK_STATS_EN adds the relock_cnt output.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_PROFILES  = 4,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3,
  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [PW-1:0] req_profile,
  output logic          req_ready,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    idsel,
  output logic [5:0]    fbdsel,
  output logic [5:0]    odsel,
  output logic          locked,
  output logic          busy,
  output logic [PW-1:0] cur_profile,
  output logic          err
`ifdef PLL_LOCK_STATS_EN
  ,
  output logic [7:0]    relock_cnt
`endif
);

  localparam int CNT_MAX = (RESET_CYCLES > LOCK_TIMEOUT)
                         ? ((RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES)
                         : ((LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock_s already counts toward the settle window.
  localparam logic [CW-1:0] SET_LAST  = CW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  logic          lock_s;
  pll_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [PW-1:0] prof_q, prof_d;
  pll_profile_t  codes_q, codes_d;
  logic          low_q, low_d;
  logic          accept, in_range, change, attempt_fail;

  pll_lock_sync u_lock_sync (
    .clk_i   (clkin),
    .rst_i   (rst),
    .async_i (pll_lock),
    .sync_o  (lock_s)
  );

  assign accept    = req_valid && req_ready;
  assign in_range  = 32'(req_profile) < 32'(NUM_PROFILES);
  assign change    = accept && in_range && !((state_q == ST_RUN) && (req_profile == prof_q));
  assign retry_inc = retry_q + RW'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    prof_d       = prof_q;
    low_d        = 1'b0;
    attempt_fail = 1'b0;
    case (state_q)
      ST_HOLD_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = (SETTLE_CYCLES > 1) ? ST_SETTLE : ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SETTLE: begin
        if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (cnt_q == SET_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        // Two consecutive low samples count as a real loss; one is treated as a glitch.
        if (!lock_s && low_q) begin
          state_d = ST_HOLD_RST;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          low_d = !lock_s;
        end
      end
      ST_FAIL: ;
      default: begin
        state_d = ST_HOLD_RST;
        cnt_d   = '0;
      end
    endcase

    if (attempt_fail) begin
      retry_d = retry_inc;
      cnt_d   = '0;
      state_d = (retry_inc == RETRY_LIM) ? ST_FAIL : ST_HOLD_RST;
    end

    if (change) begin
      state_d = ST_HOLD_RST;
      prof_d  = req_profile;
      cnt_d   = '0;
      retry_d = '0;
      low_d   = 1'b0;
    end

    codes_d = profile_codes(4'(prof_d));
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= ST_HOLD_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      prof_q  <= PW'(DEFAULT_PROFILE);
      codes_q <= profile_codes(4'(DEFAULT_PROFILE));
      low_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      prof_q  <= prof_d;
      codes_q <= codes_d;
      low_q   <= low_d;
    end
  end

  assign pll_reset   = (state_q == ST_HOLD_RST) || (state_q == ST_FAIL);
  assign locked      = (state_q == ST_RUN);
  assign busy        = (state_q == ST_HOLD_RST) || (state_q == ST_WAIT_LOCK) || (state_q == ST_SETTLE);
  assign req_ready   = (state_q == ST_RUN) || (state_q == ST_FAIL);
  assign err         = (state_q == ST_FAIL);
  assign cur_profile = prof_q;
  assign idsel       = codes_q.idsel;
  assign fbdsel      = codes_q.fbdsel;
  assign odsel       = codes_q.odsel;

`ifdef PLL_LOCK_STATS_EN
  logic [7:0] relock_q;
  logic       lock_loss;

  assign lock_loss = (state_q == ST_RUN) && !lock_s && low_q && !change;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      relock_q <= 8'd0;
    end else if (change) begin
      relock_q <= 8'd0;
    end else if (lock_loss && (relock_q != 8'hFF)) begin
      relock_q <= relock_q + 8'd1;
    end
  end

  assign relock_cnt = relock_q;
`endif

endmodule
